// File: rtl/branch_predictor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_pkg
// Brief    : Shared FSM state encoding and 2-bit counter constants for the
//            branch predictor.
// Revision : 1.0 - initial release
// ============================================================================
package branch_predictor_pkg;

    // Predictor control state: table initialisation, then normal operation
    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } bp_state_t;

    // Two-bit saturating counter values
    localparam logic [1:0] SNT = 2'b00;   // strongly not taken
    localparam logic [1:0] WNT = 2'b01;   // weakly not taken
    localparam logic [1:0] WT  = 2'b10;   // weakly taken
    localparam logic [1:0] ST  = 2'b11;   // strongly taken

endpackage : branch_predictor_pkg
`default_nettype wire

// File: rtl/bp_sat_ctr.sv
`default_nettype none
// ============================================================================
// Module   : bp_sat_ctr
// Brief    : Next value of a 2-bit saturating counter (up on taken, down on
//            not taken, pinned at SNT and ST).
// Revision : 1.0 - initial release
// ============================================================================
module bp_sat_ctr
    import branch_predictor_pkg::*;
(
    input  logic [1:0] i_ctr,
    input  logic       i_inc,
    output logic [1:0] o_ctr
);

    // Saturating step in the direction of the resolved outcome
    always_comb begin
        o_ctr = i_ctr;
        if (i_inc) begin
            if (i_ctr != ST)
                o_ctr = i_ctr + 2'b01;
        end else begin
            if (i_ctr != SNT)
                o_ctr = i_ctr - 2'b01;
        end
    end

endmodule : bp_sat_ctr
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Brief    : Direct-mapped branch target buffer with 2-bit saturating
//            direction counters, combinational lookup and a self-clearing
//            INIT phase after reset.
//            Optional macro BP_STATS_EN adds UpdCnt / MispredCnt outputs.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] InstrAddr,
    output logic [31:0] Predict,
    output logic        PCSource,
    output logic        Busy,
    input  logic        UpdValid,
    input  logic [31:0] UpdPC,
    input  logic        UpdTaken,
    input  logic [31:0] UpdTarget,
    input  logic        UpdPredTaken
`ifdef BP_STATS_EN
    ,
    output logic [31:0] UpdCnt,
    output logic [31:0] MispredCnt
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(ENTRIES - 1);

    // Predictor table
    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]      r_target [ENTRIES];
    logic [1:0]       r_ctr    [ENTRIES];

    bp_state_t        r_state;
    bp_state_t        w_state_next;
    logic [IDX_W-1:0] r_init_idx;
    logic [IDX_W-1:0] w_init_idx_next;

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic             w_lk_hit;
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;
    logic             w_upd_run;
    logic [1:0]       w_ctr_next;

    assign w_lk_idx  = InstrAddr[IDX_W+1:2];
    assign w_lk_tag  = InstrAddr[31:IDX_W+2];
    assign w_up_idx  = UpdPC[IDX_W+1:2];
    assign w_up_tag  = UpdPC[31:IDX_W+2];
    assign w_lk_hit  = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_up_hit  = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_upd_run = UpdValid && (r_state == RUN) && !Rst;

    assign Busy     = (r_state == INIT);
    assign PCSource = w_lk_hit && r_ctr[w_lk_idx][1] && (r_state == RUN);
    assign Predict  = w_lk_hit ? r_target[w_lk_idx] : 32'b0;

    bp_sat_ctr u_sat_ctr (
        .i_ctr (r_ctr[w_up_idx]),
        .i_inc (UpdTaken),
        .o_ctr (w_ctr_next)
    );

    // State and init-index register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state    <= INIT;
            r_init_idx <= '0;
        end else begin
            r_state    <= w_state_next;
            r_init_idx <= w_init_idx_next;
        end
    end

    // Next state: walk every entry once in INIT, then stay in RUN
    always_comb begin
        w_state_next    = r_state;
        w_init_idx_next = r_init_idx;
        if (r_state == INIT) begin
            w_init_idx_next = r_init_idx + 1'b1;
            if (r_init_idx == c_last_idx) begin
                w_state_next    = RUN;
                w_init_idx_next = '0;
            end
        end
    end

    // Table writes: clearing during INIT, training/allocation during RUN
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            if (r_state == INIT) begin
                r_valid[r_init_idx] <= 1'b0;
                r_ctr[r_init_idx]   <= WNT;
            end else if (UpdValid) begin
                if (w_up_hit) begin
                    r_ctr[w_up_idx] <= w_ctr_next;
                    if (UpdTaken)
                        r_target[w_up_idx] <= UpdTarget;
                end else if (UpdTaken) begin
                    r_valid[w_up_idx]  <= 1'b1;
                    r_tag[w_up_idx]    <= w_up_tag;
                    r_target[w_up_idx] <= UpdTarget;
                    r_ctr[w_up_idx]    <= WT;
                end
            end
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] r_upd_cnt;
    logic [31:0] r_mispred_cnt;

    // Statistics counters over RUN-phase updates, wrapping naturally
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_upd_cnt     <= '0;
            r_mispred_cnt <= '0;
        end else if (w_upd_run) begin
            r_upd_cnt <= r_upd_cnt + 32'd1;
            if (UpdTaken != UpdPredTaken)
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
        end
    end

    assign UpdCnt     = r_upd_cnt;
    assign MispredCnt = r_mispred_cnt;

    logic w_unused_ok;
    assign w_unused_ok = ^{InstrAddr[1:0], UpdPC[1:0]};
`else
    // Byte-offset bits and the statistics-only input carry no state here
    logic w_unused_ok;
    assign w_unused_ok = ^{InstrAddr[1:0], UpdPC[1:0], UpdPredTaken, w_upd_run};
`endif

endmodule : branch_predictor
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor
// Brief    : Self-checking bench for branch_predictor (ENTRIES=16) with a
//            behavioural table model for randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    localparam int N = 16;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic [31:0] InstrAddr = '0;
    logic [31:0] Predict;
    logic        PCSource;
    logic        Busy;
    logic        UpdValid = 1'b0;
    logic [31:0] UpdPC = '0;
    logic        UpdTaken = 1'b0;
    logic [31:0] UpdTarget = '0;
    logic        UpdPredTaken = 1'b0;
`ifdef BP_STATS_EN
    logic [31:0] UpdCnt;
    logic [31:0] MispredCnt;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit          m_valid  [N];
    int unsigned m_tag    [N];
    logic [31:0] m_target [N];
    int          m_ctr    [N];

    branch_predictor #(.ENTRIES(N)) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .InstrAddr    (InstrAddr),
        .Predict      (Predict),
        .PCSource     (PCSource),
        .Busy         (Busy),
        .UpdValid     (UpdValid),
        .UpdPC        (UpdPC),
        .UpdTaken     (UpdTaken),
        .UpdTarget    (UpdTarget),
        .UpdPredTaken (UpdPredTaken)
`ifdef BP_STATS_EN
        ,
        .UpdCnt       (UpdCnt),
        .MispredCnt   (MispredCnt)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reset and run through INIT without checks
    task automatic reset_and_init();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        for (int i = 0; i < 200 && Busy; i++) tick();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
    endtask

    task automatic do_update(input logic [31:0] pc, input logic tk,
                             input logic [31:0] tgt, input logic ptk);
        UpdValid = 1'b1; UpdPC = pc; UpdTaken = tk; UpdTarget = tgt; UpdPredTaken = ptk;
        tick();
        UpdValid = 1'b0;
    endtask

    task automatic test_reset();
        int cnt;
        Rst = 1'b1;
        tick();
        tests++;
        if (Busy !== 1'b1 || PCSource !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: Busy=%b PCSource=%b, need Busy=1 PCSource=0", Busy, PCSource);
        end
        Rst = 1'b0;
        cnt = 0;
        while (Busy === 1'b1 && cnt < 100) begin
            InstrAddr = $urandom;
            #1;
            if (PCSource !== 1'b0) begin
                tests++; fails++;
                $display("FAIL init_pcsource: PCSource=%b during INIT cycle %0d, need 0", PCSource, cnt);
            end
            cnt++;
            tick();
        end
        tests++;
        if (cnt !== N) begin
            fails++;
            $display("FAIL init_length: Busy high %0d cycles, need %0d", cnt, N);
        end
        tests++;
        if (Busy !== 1'b0) begin
            fails++;
            $display("FAIL busy_after_init: Busy=%b need 0", Busy);
        end
    endtask

    // Update in the last INIT cycle, to an already-cleared entry, must be dropped
    task automatic test_init_drop();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        for (int i = 0; i < N - 1; i++) tick();
        tests++;
        if (Busy !== 1'b1) begin
            fails++;
            $display("FAIL init_last_cycle: Busy=%b need 1", Busy);
        end
        do_update(32'h100, 1'b1, 32'h200, 1'b0);
        InstrAddr = 32'h100;
        #1;
        tests++;
        if (Busy !== 1'b0 || PCSource !== 1'b0 || Predict !== 32'h0) begin
            fails++;
            $display("FAIL init_drop: Busy=%b PCSource=%b Predict=%h, need 0/0/00000000", Busy, PCSource, Predict);
        end
    endtask

    task automatic test_counter();
        reset_and_init();
        do_update(32'h100, 1'b1, 32'h200, 1'b0);
        InstrAddr = 32'h100; #1;
        tests++;
        if (PCSource !== 1'b1 || Predict !== 32'h200) begin
            fails++;
            $display("FAIL alloc_hit: PCSource=%b Predict=%h, need 1/00000200", PCSource, Predict);
        end
        InstrAddr = 32'h104; #1;
        tests++;
        if (PCSource !== 1'b0) begin
            fails++;
            $display("FAIL neighbour_miss: PCSource=%b need 0", PCSource);
        end
        do_update(32'h100, 1'b0, 32'h999, 1'b1);
        InstrAddr = 32'h100; #1;
        tests++;
        if (PCSource !== 1'b0 || Predict !== 32'h200) begin
            fails++;
            $display("FAIL ctr_wnt: PCSource=%b Predict=%h, need 0/00000200", PCSource, Predict);
        end
        do_update(32'h100, 1'b0, 32'h999, 1'b0);
        do_update(32'h100, 1'b0, 32'h999, 1'b0);
        InstrAddr = 32'h100; #1;
        tests++;
        if (PCSource !== 1'b0 || Predict !== 32'h200) begin
            fails++;
            $display("FAIL ctr_snt_valid: PCSource=%b Predict=%h, need 0/00000200", PCSource, Predict);
        end
        // From SNT: one taken reaches WNT (still not taken)
        do_update(32'h100, 1'b1, 32'h200, 1'b0);
        InstrAddr = 32'h100; #1;
        tests++;
        if (PCSource !== 1'b0) begin
            fails++;
            $display("FAIL ctr_floor_sat: PCSource=%b need 0", PCSource);
        end
        do_update(32'h100, 1'b1, 32'h200, 1'b0);
        do_update(32'h100, 1'b1, 32'h200, 1'b1);
        do_update(32'h100, 1'b1, 32'h200, 1'b1);
        do_update(32'h100, 1'b0, 32'h999, 1'b1);
        InstrAddr = 32'h100; #1;
        tests++;
        if (PCSource !== 1'b1 || Predict !== 32'h200) begin
            fails++;
            $display("FAIL ctr_st_to_wt: PCSource=%b Predict=%h, need 1/00000200", PCSource, Predict);
        end
        do_update(32'h100, 1'b0, 32'h999, 1'b1);
        InstrAddr = 32'h100; #1;
        tests++;
        if (PCSource !== 1'b0) begin
            fails++;
            $display("FAIL ctr_ceiling_sat: PCSource=%b need 0", PCSource);
        end
    endtask

    task automatic test_alias();
        reset_and_init();
        do_update(32'h100, 1'b1, 32'h200, 1'b0);
        InstrAddr = 32'h140; #1;
        tests++;
        if (PCSource !== 1'b0 || Predict !== 32'h0) begin
            fails++;
            $display("FAIL alias_miss: PCSource=%b Predict=%h, need 0/00000000", PCSource, Predict);
        end
        do_update(32'h140, 1'b1, 32'h300, 1'b0);
        InstrAddr = 32'h140; #1;
        tests++;
        if (PCSource !== 1'b1 || Predict !== 32'h300) begin
            fails++;
            $display("FAIL alias_alloc: PCSource=%b Predict=%h, need 1/00000300", PCSource, Predict);
        end
        InstrAddr = 32'h100; #1;
        tests++;
        if (PCSource !== 1'b0 || Predict !== 32'h0) begin
            fails++;
            $display("FAIL alias_evict: PCSource=%b Predict=%h, need 0/00000000", PCSource, Predict);
        end
        // Not-taken miss must leave the table alone
        do_update(32'h100, 1'b0, 32'h500, 1'b0);
        InstrAddr = 32'h140; #1;
        tests++;
        if (PCSource !== 1'b1 || Predict !== 32'h300) begin
            fails++;
            $display("FAIL miss_nt_nochange: PCSource=%b Predict=%h, need 1/00000300", PCSource, Predict);
        end
    endtask

    task automatic test_same_cycle();
        reset_and_init();
        do_update(32'h100, 1'b1, 32'h200, 1'b0);
        InstrAddr = 32'h100;
        UpdValid = 1'b1; UpdPC = 32'h100; UpdTaken = 1'b1; UpdTarget = 32'h400; UpdPredTaken = 1'b1;
        #1;
        tests++;
        if (Predict !== 32'h200) begin
            fails++;
            $display("FAIL same_cycle_old: Predict=%h need 00000200", Predict);
        end
        tick();
        UpdValid = 1'b0;
        #1;
        tests++;
        if (Predict !== 32'h400 || PCSource !== 1'b1) begin
            fails++;
            $display("FAIL same_cycle_new: PCSource=%b Predict=%h, need 1/00000400", PCSource, Predict);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        reset_and_init();
        for (int c = 0; c < 600; c++) begin
            logic [31:0] la, ua;
            int li, ui;
            int unsigned lt, ut;
            logic exp_src;
            logic [31:0] exp_pred;
            // Small address pool: 3 tags x 4 indices, plus random byte offsets
            la = {$urandom_range(0, 2) * 32'h40 + $urandom_range(0, 3) * 32'h4} | 32'($urandom_range(0, 3));
            ua = {$urandom_range(0, 2) * 32'h40 + $urandom_range(0, 3) * 32'h4} | 32'($urandom_range(0, 3));
            if (c % 7 == 0) la = $urandom;
            InstrAddr    = la;
            UpdValid     = ($urandom_range(0, 2) != 0);
            UpdPC        = ua;
            UpdTaken     = $urandom_range(0, 1);
            UpdTarget    = $urandom;
            UpdPredTaken = $urandom_range(0, 1);
            #1;
            li = int'((la / 4) % N);
            lt = la / (4 * N);
            exp_src  = m_valid[li] && m_tag[li] == lt && m_ctr[li] >= 2;
            exp_pred = (m_valid[li] && m_tag[li] == lt) ? m_target[li] : 32'h0;
            tests++;
            if (PCSource !== exp_src || Predict !== exp_pred) begin
                fails++;
                errs++;
                if (errs <= 5)
                    $display("FAIL random_lookup: cycle %0d addr=%h PCSource=%b Predict=%h, need %b/%h",
                             c, la, PCSource, Predict, exp_src, exp_pred);
            end
            if (UpdValid) begin
                ui = int'((ua / 4) % N);
                ut = ua / (4 * N);
                if (m_valid[ui] && m_tag[ui] == ut) begin
                    if (UpdTaken) begin
                        m_ctr[ui] = (m_ctr[ui] + 1 > 3) ? 3 : m_ctr[ui] + 1;
                        m_target[ui] = UpdTarget;
                    end else begin
                        m_ctr[ui] = (m_ctr[ui] - 1 < 0) ? 0 : m_ctr[ui] - 1;
                    end
                end else if (UpdTaken) begin
                    m_valid[ui] = 1'b1; m_tag[ui] = ut;
                    m_target[ui] = UpdTarget; m_ctr[ui] = 2;
                end
            end
            tick();
        end
        UpdValid = 1'b0;
    endtask

`ifdef BP_STATS_EN
    task automatic test_stats();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        do_update(32'h100, 1'b1, 32'h200, 1'b0);   // dropped in INIT
        for (int i = 0; i < 200 && Busy; i++) tick();
        do_update(32'h100, 1'b1, 32'h200, 1'b1);
        do_update(32'h100, 1'b0, 32'h200, 1'b0);
        do_update(32'h180, 1'b1, 32'h200, 1'b0);
        do_update(32'h100, 1'b1, 32'h200, 1'b1);
        tests++;
        if (UpdCnt !== 32'd4 || MispredCnt !== 32'd1) begin
            fails++;
            $display("FAIL stats: UpdCnt=%0d MispredCnt=%0d, need 4/1", UpdCnt, MispredCnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_init_drop();
        test_counter();
        test_alias();
        test_same_cycle();
        test_random();
`ifdef BP_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_branch_predictor
`default_nettype wire
